// File: rtl/cam_req_ctrl.sv
// cam_req_ctrl
//   Request front-end for the CAM lookup/storage block. Incoming insert/read/
//   delete requests are queued in a small FIFO, issued to the CAM at most one
//   per cycle, and the CAM's same-cycle result is captured into a registered
//   response slot with valid/ready backpressure. Saturating statistics count
//   read hits, read misses and failed inserts.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready = !fifo_full)
//   req_cmd/key/data          request: 0=INS 1=RD 2=DEL 3=NOP (NOP dropped)
//   cam_cmd/key/data          command to CAM (NOP and zeros when not issuing)
//   cam_out_valid/data        CAM combinational result for current cam_cmd
//   rsp_valid/rsp_ready       response slot handshake
//   rsp_cmd/ok/data           captured response fields
//   rd_hit_cnt, rd_miss_cnt,
//   ins_fail_cnt              saturating statistics counters
module cam_req_ctrl #(
  parameter int unsigned K_WIDTH    = 10,
  parameter int unsigned D_WIDTH    = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [K_WIDTH-1:0]   req_key,
  input  logic [D_WIDTH-1:0]   req_data,
  output logic [1:0]           cam_cmd,
  output logic [K_WIDTH-1:0]   cam_key,
  output logic [D_WIDTH-1:0]   cam_data,
  input  logic                 cam_out_valid,
  input  logic [D_WIDTH-1:0]   cam_out_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_cmd,
  output logic                 rsp_ok,
  output logic [D_WIDTH-1:0]   rsp_data,
  output logic [CNT_WIDTH-1:0] rd_hit_cnt,
  output logic [CNT_WIDTH-1:0] rd_miss_cnt,
  output logic [CNT_WIDTH-1:0] ins_fail_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    CMD_INS = 2'd0,
    CMD_RD  = 2'd1,
    CMD_DEL = 2'd2,
    CMD_NOP = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Request FIFO storage
  logic [1:0]         cmd_mem_q  [FIFO_DEPTH];
  logic [K_WIDTH-1:0] key_mem_q  [FIFO_DEPTH];
  logic [D_WIDTH-1:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_cmd_q, rsp_cmd_d;
  logic               rsp_ok_q, rsp_ok_d;
  logic [D_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [CNT_WIDTH-1:0] rd_hit_q, rd_hit_d;
  logic [CNT_WIDTH-1:0] rd_miss_q, rd_miss_d;
  logic [CNT_WIDTH-1:0] ins_fail_q, ins_fail_d;

  logic               fifo_nonempty;
  logic               fifo_full;
  logic               push;
  logic               issue;
  state_e             state;
  logic [1:0]         head_cmd;
  logic [K_WIDTH-1:0] head_key;
  logic [D_WIDTH-1:0] head_data;

  assign fifo_nonempty = (occ_q != '0);
  assign fifo_full     = (occ_q == OCC_FULL);
  assign req_ready     = !fifo_full;
  assign push          = req_valid && !fifo_full && (req_cmd != CMD_NOP);

  assign head_cmd  = cmd_mem_q[rd_ptr_q];
  assign head_key  = key_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Controller state is decoded from registered occupancy and the response
  // slot rather than stored, so it can never disagree with them.
  always_comb begin
    state = ST_IDLE;
    if (rsp_valid_q && !rsp_ready) begin
      state = ST_STALL;
    end else if (fifo_nonempty) begin
      state = ST_BUSY;
    end
  end

  assign issue = (state == ST_BUSY);

  // CAM command drive: head of FIFO while issuing, NOP otherwise
  always_comb begin
    cam_cmd  = CMD_NOP;
    cam_key  = '0;
    cam_data = '0;
    if (issue) begin
      cam_cmd  = head_cmd;
      cam_key  = head_key;
      cam_data = head_data;
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, issue})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Response slot: an issue overwrites the slot even while it is being
  // drained, so the slot only empties on a drain without a new issue.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_cmd_d   = rsp_cmd_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_data_d  = rsp_data_q;
    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_cmd_d   = head_cmd;
      rsp_ok_d    = (head_cmd == CMD_DEL) ? 1'b1 : cam_out_valid;
      rsp_data_d  = ((head_cmd == CMD_RD) && cam_out_valid) ? cam_out_data : '0;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Saturating statistics
  always_comb begin
    rd_hit_d   = rd_hit_q;
    rd_miss_d  = rd_miss_q;
    ins_fail_d = ins_fail_q;
    if (issue) begin
      if (head_cmd == CMD_RD) begin
        if (cam_out_valid) begin
          if (rd_hit_q != '1) rd_hit_d = rd_hit_q + CNT_WIDTH'(1);
        end else begin
          if (rd_miss_q != '1) rd_miss_d = rd_miss_q + CNT_WIDTH'(1);
        end
      end else if ((head_cmd == CMD_INS) && !cam_out_valid) begin
        if (ins_fail_q != '1) ins_fail_d = ins_fail_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem_q[wr_ptr_q]  <= req_cmd;
      key_mem_q[wr_ptr_q]  <= req_key;
      data_mem_q[wr_ptr_q] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cmd_q   <= CMD_NOP;
      rsp_ok_q    <= 1'b0;
      rsp_data_q  <= '0;
      rd_hit_q    <= '0;
      rd_miss_q   <= '0;
      ins_fail_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cmd_q   <= rsp_cmd_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_data_q  <= rsp_data_d;
      rd_hit_q    <= rd_hit_d;
      rd_miss_q   <= rd_miss_d;
      ins_fail_q  <= ins_fail_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_cmd      = rsp_cmd_q;
  assign rsp_ok       = rsp_ok_q;
  assign rsp_data     = rsp_data_q;
  assign rd_hit_cnt   = rd_hit_q;
  assign rd_miss_cnt  = rd_miss_q;
  assign ins_fail_cnt = ins_fail_q;

endmodule

// File: tb/tb_cam_req_ctrl.sv
// Testbench for cam_req_ctrl: directed requests, a 16-entry behavioural CAM
// attached to the command port, and a queue of hand-computed responses popped
// by a monitor thread whenever a response is handed over.
module tb_cam_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [9:0]  req_key;
  logic [9:0]  req_data;
  logic [1:0]  cam_cmd;
  logic [9:0]  cam_key;
  logic [9:0]  cam_data;
  logic        cam_out_valid;
  logic [9:0]  cam_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_cmd;
  logic        rsp_ok;
  logic [9:0]  rsp_data;
  logic [15:0] rd_hit_cnt;
  logic [15:0] rd_miss_cnt;
  logic [15:0] ins_fail_cnt;

  cam_req_ctrl #(
    .K_WIDTH(10), .D_WIDTH(10), .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_key(req_key), .req_data(req_data),
    .cam_cmd(cam_cmd), .cam_key(cam_key), .cam_data(cam_data),
    .cam_out_valid(cam_out_valid), .cam_out_data(cam_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cmd(rsp_cmd), .rsp_ok(rsp_ok), .rsp_data(rsp_data),
    .rd_hit_cnt(rd_hit_cnt), .rd_miss_cnt(rd_miss_cnt),
    .ins_fail_cnt(ins_fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16-entry CAM
  logic       cam_v [16];
  logic [9:0] cam_k [16];
  logic [9:0] cam_d [16];
  logic       cam_clr;
  int         match_idx;
  int         free_idx;

  always_comb begin
    match_idx = -1;
    free_idx  = -1;
    for (int i = 15; i >= 0; i--) begin
      if (cam_v[i] && cam_k[i] == cam_key) match_idx = i;
      if (!cam_v[i]) free_idx = i;
    end
  end

  always_comb begin
    cam_out_valid = 1'b0;
    cam_out_data  = '0;
    case (cam_cmd)
      2'd0: cam_out_valid = (match_idx >= 0) || (free_idx >= 0);
      2'd1: begin
        cam_out_valid = (match_idx >= 0);
        if (match_idx >= 0) cam_out_data = cam_d[match_idx];
      end
      2'd2: cam_out_valid = (match_idx >= 0);
      default: cam_out_valid = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (cam_clr) begin
      for (int i = 0; i < 16; i++) cam_v[i] <= 1'b0;
    end else begin
      case (cam_cmd)
        2'd0: begin
          if (match_idx >= 0) begin
            cam_d[match_idx] <= cam_data;
          end else if (free_idx >= 0) begin
            cam_v[free_idx] <= 1'b1;
            cam_k[free_idx] <= cam_key;
            cam_d[free_idx] <= cam_data;
          end
        end
        2'd2: if (match_idx >= 0) cam_v[match_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [1:0] cmd;
    logic       ok;
    logic [9:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got cmd=%0d ok=%0d data=0x%0h with nothing expected",
                   rsp_cmd, rsp_ok, rsp_data);
        end else if (rsp_ready) begin
          e = exp_q.pop_front();
          check("rsp", 32'({rsp_cmd, rsp_ok, rsp_data}), 32'(e));
        end else begin
          check("rsp_hold", 32'({rsp_cmd, rsp_ok, rsp_data}), 32'(exp_q[0]));
          check("stall_nop", 32'(cam_cmd), 32'd3);
        end
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [9:0] k, input logic [9:0] d,
                      input logic [1:0] ec, input logic eok, input logic [9:0] ed);
    logic acc;
    exp_t e;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_key   = k;
    req_data  = d;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_cmd   = 2'd3;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: request cmd=%0d key=0x%0h not accepted in 40 cycles", c, k);
    end else begin
      e.cmd  = ec;
      e.ok   = eok;
      e.data = ed;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 80) begin
      sync();
      n++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, rsp_valid=%0d", exp_q.size(), rsp_valid);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    cam_clr   = 1'b1;
    req_valid = 1'b0;
    req_cmd   = 2'd3;
    req_key   = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) sync();
    rst     = 1'b0;
    cam_clr = 1'b0;

    // Reset / idle state
    repeat (5) sync();
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_cam_cmd", 32'(cam_cmd), 32'd3);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_cmd", 32'(rsp_cmd), 32'd3);
    check("idle_cnts", 32'({rd_hit_cnt, rd_miss_cnt} | 32'(ins_fail_cnt)), 32'd0);
    sync();

    // INS then RD of the same key, back to back
    send(2'd0, 10'h005, 10'h2A3, 2'd0, 1'b1, 10'h000);
    send(2'd1, 10'h005, 10'h000, 2'd1, 1'b1, 10'h2A3);
    check("rd_issue_cmd", 32'(cam_cmd), 32'd1);
    check("rd_issue_key", 32'(cam_key), 32'h005);
    wait_drain();
    check("hit_cnt_1", 32'(rd_hit_cnt), 32'd1);

    // Read miss, then delete
    send(2'd1, 10'h3FF, 10'h000, 2'd1, 1'b0, 10'h000);
    send(2'd2, 10'h3FF, 10'h000, 2'd2, 1'b1, 10'h000);
    wait_drain();
    check("miss_cnt_1", 32'(rd_miss_cnt), 32'd1);
    check("hit_cnt_1b", 32'(rd_hit_cnt), 32'd1);

    // Backpressure: one held response plus four queued
    rsp_ready = 1'b0;
    send(2'd1, 10'h005, 10'h000, 2'd1, 1'b1, 10'h2A3);
    send(2'd1, 10'h007, 10'h000, 2'd1, 1'b0, 10'h000);
    send(2'd0, 10'h007, 10'h001, 2'd0, 1'b1, 10'h000);
    send(2'd1, 10'h007, 10'h000, 2'd1, 1'b1, 10'h001);
    send(2'd2, 10'h005, 10'h000, 2'd2, 1'b1, 10'h000);
    @(negedge clk);
    check("full_req_ready", 32'(req_ready), 32'd0);
    check("full_cam_nop", 32'(cam_cmd), 32'd3);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    sync();
    repeat (2) sync();
    rsp_ready = 1'b1;
    wait_drain();
    check("hit_cnt_3", 32'(rd_hit_cnt), 32'd3);
    check("miss_cnt_2", 32'(rd_miss_cnt), 32'd2);

    // Fill the CAM, then overflow it
    cam_clr = 1'b1;
    sync();
    cam_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(2'd0, 10'(10'h100 + i), 10'(10'h040 + i), 2'd0, 1'b1, 10'h000);
    end
    send(2'd0, 10'h200, 10'h155, 2'd0, 1'b0, 10'h000);
    send(2'd0, 10'h100, 10'h3AB, 2'd0, 1'b1, 10'h000);
    send(2'd1, 10'h100, 10'h000, 2'd1, 1'b1, 10'h3AB);
    wait_drain();
    check("ins_fail_1", 32'(ins_fail_cnt), 32'd1);
    check("hit_cnt_4", 32'(rd_hit_cnt), 32'd4);
    check("miss_cnt_2b", 32'(rd_miss_cnt), 32'd2);

    // Reset with a held response and three queued requests
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(2'd1, 10'h101, 10'h000, 2'd1, 1'b1, 10'h041);
    end
    @(negedge clk);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pre_rst_req_ready", 32'(req_ready), 32'd1);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_cmd", 32'(rsp_cmd), 32'd3);
    check("rst_hit_cnt", 32'(rd_hit_cnt), 32'd0);
    check("rst_ins_fail", 32'(ins_fail_cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("rst_cam_nop", 32'(cam_cmd), 32'd3);
      @(negedge clk);
    end
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
